// File: rtl/multu_sequencer_if.sv
// Handshake and result bus between the pipeline and the MULTU sequencer.
interface multu_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              nop;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              hi_req;
  logic              lo_req;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Pipeline side: issues requests, observes status and HI/LO.
  modport master (
    output start, nop, a, b, hi_req, lo_req,
    input  busy, stall, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, nop, a, b, hi_req, lo_req,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/multu_sequencer.sv
// Iterative shift-add unsigned multiplier owning the architectural HI/LO pair.
// One product bit is retired per RUN cycle; HI/LO update only when DONE closes.
module multu_sequencer #(
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  multu_sequencer_if.slave bus
);

  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ProdW = 2 * DATA_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [ProdW-1:0]  prod_q, prod_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W:0]   upper;

  // Next-state and datapath: accept, shift-add iterations, HI/LO commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    upper   = prod_q[2*DATA_W:DATA_W];
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.nop) begin
          mcand_d = bus.a;
          prod_d  = {{(DATA_W+1){1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Upper half is always < 2^DATA_W here, so the extra bit holds the carry.
        if (prod_q[0]) begin
          upper = prod_q[2*DATA_W:DATA_W] + {1'b0, mcand_q};
        end
        prod_d = {1'b0, upper, prod_q[DATA_W-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        hi_d    = prod_q[2*DATA_W-1:DATA_W];
        lo_d    = prod_q[DATA_W-1:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StDone);
  // Freeze only real consumers of the unit while it is occupied; never during reset.
  assign bus.stall = ~rst & bus.busy & ~bus.nop & (bus.start | bus.hi_req | bus.lo_req);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer: vector table plus multi-cycle sequences.
module tb_multu_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multu_sequencer_if #(.DATA_W(W)) bus ();
  multu_sequencer #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_hi, exp_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.nop    = 1'b0;
    bus.hi_req = 1'b0;
    bus.lo_req = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
  endtask

  // Single MULTU issued for one cycle; checks timing and the committed result.
  task automatic run_vec(input int idx, input vec_t v);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    bus.a = v.a; bus.b = v.b; bus.start = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_busy_c0", idx), bus.busy, 0);
    next_cycle();
    bus.start = 1'b0; bus.a = '1; bus.b = '1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_at = c; end
      if (c == 33) begin
        chk($sformatf("v%0d_hi_hold", idx), bus.hi, exp_hi);
        chk($sformatf("v%0d_lo_hold", idx), bus.lo, exp_lo);
      end
      next_cycle();
    end
    @(negedge clk);
    chk($sformatf("v%0d_busy_cycles", idx), busy_cnt, 33);
    chk($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    chk($sformatf("v%0d_done_cycle", idx), done_at, 33);
    chk($sformatf("v%0d_busy_c34", idx), bus.busy, 0);
    chk($sformatf("v%0d_hi", idx), bus.hi, v.hi);
    chk($sformatf("v%0d_lo", idx), bus.lo, v.lo);
    exp_hi = v.hi; exp_lo = v.lo;
    bus.a = '0; bus.b = '0;
    next_cycle();
  endtask

  initial begin
    int bad, dones;
    vecs[0] = '{a: 32'd3,         b: 32'd5,         hi: 32'h0,        lo: 32'd15};
    vecs[1] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  hi: 32'hFFFFFFFE, lo: 32'h00000001};
    vecs[2] = '{a: 32'h0,         b: 32'h12345678,  hi: 32'h0,        lo: 32'h0};
    vecs[3] = '{a: 32'h12345678,  b: 32'h00000100,  hi: 32'h00000012, lo: 32'h34567800};
    vecs[4] = '{a: 32'd7,         b: 32'd0,         hi: 32'h0,        lo: 32'h0};
    vecs[5] = '{a: 32'h80000000,  b: 32'h80000000,  hi: 32'h40000000, lo: 32'h0};
    vecs[6] = '{a: 32'hFFFFFFFF,  b: 32'd2,         hi: 32'h00000001, lo: 32'hFFFFFFFE};
    vecs[7] = '{a: 32'hDEADBEEF,  b: 32'd1,         hi: 32'h0,        lo: 32'hDEADBEEF};

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    exp_hi = '0; exp_lo = '0;
    next_cycle();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // start qualified by nop in IDLE is ignored.
    bus.start = 1'b1; bus.nop = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.stall !== 1'b0) bad++;
      next_cycle();
    end
    @(negedge clk);
    chk("nop_no_accept", bad, 0);
    chk("nop_busy_after", bus.busy, 0);
    chk("nop_lo_kept", bus.lo, exp_lo);
    idle_inputs();
    next_cycle();

    // hi_req held from cycle 5; nop bubble in cycle 10 masks the stall.
    bus.start = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'h10;
    next_cycle();
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bad = 0;
    for (int c = 1; c <= 34; c++) begin
      bus.hi_req = (c >= 5);
      bus.nop    = (c == 10);
      @(negedge clk);
      if (bus.stall !== ((c >= 5) && (c <= 33) && (c != 10))) bad++;
      if (c == 5)  chk("hireq_stall_c5", bus.stall, 1);
      if (c == 10) chk("hireq_nop_c10", bus.stall, 0);
      if (c == 34) begin
        chk("hireq_stall_c34", bus.stall, 0);
        chk("hireq_hi_new", bus.hi, 32'hF);
        chk("hireq_lo_new", bus.lo, 32'hFFFFFFF0);
      end
      if (c < 34) next_cycle();
    end
    chk("hireq_stall_window", bad, 0);
    exp_hi = 32'hF; exp_lo = 32'hFFFFFFF0;
    next_cycle();
    idle_inputs();
    next_cycle();

    // start+hi_req in IDLE, then a second start held through the first RUN.
    bus.start = 1'b1; bus.hi_req = 1'b1; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    chk("b2b_idle_stall", bus.stall, 0);
    chk("b2b_old_hi", bus.hi, exp_hi);
    next_cycle();
    bus.hi_req = 1'b0; bus.a = 32'd7; bus.b = 32'd9;
    bad = 0; dones = 0;
    for (int c = 1; c <= 68; c++) begin
      if (c == 35) begin bus.start = 1'b0; bus.a = '0; bus.b = '0; end
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.stall !== ((c >= 1) && (c <= 33))) bad++;
      if (bus.busy !== (c != 34 && c != 68)) bad++;
      if (bus.done !== (c == 33 || c == 67)) bad++;
      if (c == 34) begin
        chk("b2b_first_hi", bus.hi, 0);
        chk("b2b_first_lo", bus.lo, 15);
      end
      if (c == 68) begin
        chk("b2b_second_hi", bus.hi, 0);
        chk("b2b_second_lo", bus.lo, 63);
      end
      if (c < 68) next_cycle();
    end
    chk("b2b_timing", bad, 0);
    chk("b2b_done_pulses", dones, 2);
    next_cycle();

    // Reset in cycle 10 of a RUN clears HI/LO and the pending product.
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd6;
    next_cycle();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    rst = 1'b1; bus.hi_req = 1'b1;
    @(negedge clk);
    chk("rstrun_stall", bus.stall, 0);
    chk("rstrun_busy_pre", bus.busy, 1);
    next_cycle();
    rst = 1'b0; bus.hi_req = 1'b0;
    @(negedge clk);
    chk("rstrun_busy", bus.busy, 0);
    chk("rstrun_hi", bus.hi, 0);
    chk("rstrun_lo", bus.lo, 0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rstrun_no_done", dones, 0);
    chk("rstrun_lo_after", bus.lo, 0);
    next_cycle();

    // Reset wins over start in the same cycle.
    rst = 1'b1; bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    next_cycle();
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", bus.busy, 0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
